// File: rtl/seven_seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment datapath among 4 sources, with a tick-based dwell.
// Define DISP_ARB_PREEMPT_EN to let source 0 (error banner) preempt any other holder.

module seven_seg_src_gate (
   input  logic        sel,
   input  logic [31:0] number,
   input  logic        mode,
   input  logic [7:0]  points,
   output logic [40:0] gated
);
   assign gated = sel ? {mode, points, number} : '0;
endmodule

module seven_seg_display_arbiter #(
   parameter int CLK_PER_TICK = 100000,
   parameter int DWELL_TICKS  = 1000
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [3:0]   req,
   input  logic [127:0] num_flat,
   input  logic [3:0]   mode_in,
   input  logic [31:0]  dp_flat,
   output logic [3:0]   grant,
   output logic [31:0]  disp_number,
   output logic         disp_mode,
   output logic [7:0]   disp_points,
   output logic         disp_active,
   output logic         tick
);
   localparam int NUM_SRC = 4;
   localparam int PW      = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
   localparam int DW      = $clog2(DWELL_TICKS + 1);

   typedef enum logic {IDLE, HOLD} state_t;
   typedef struct packed {
      logic       vld;
      logic [1:0] idx;
   } win_t;

   state_t        state, state_nxt;
   logic [PW-1:0] presc;
   logic [DW-1:0] dwell, dwell_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic [3:0]    grant_nxt;
   win_t          win_idle, win_fall, win_rot;
   logic [NUM_SRC-1:0][40:0] gated;
   logic [40:0]   merged;

   // Farthest candidate is visited first so the nearest one after ptr wins.
   function automatic win_t pick(input logic [3:0] r, input logic [1:0] p);
      win_t       w;
      logic [1:0] idx;
      w = '0;
      for (int i = NUM_SRC; i >= 1; i--) begin
         idx = p + 2'(i);
         if (r[idx]) begin
            w.vld = 1'b1;
            w.idx = idx;
         end
      end
      return w;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                               presc <= '0;
      else if (presc == PW'(CLK_PER_TICK - 1))    presc <= '0;
      else                                        presc <= presc + PW'(1);
   end
   assign tick = (presc == PW'(CLK_PER_TICK - 1));

`ifdef DISP_ARB_PREEMPT_EN
   logic req0_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) req0_q <= 1'b0;
      else          req0_q <= req[0];
   end
`endif

   // While holding, ptr always equals the granted index, so it doubles as g.
   assign win_idle = pick(req, ptr);
   assign win_fall = pick(req, ptr);
   assign win_rot  = pick(req & ~grant, ptr);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      dwell_nxt = dwell;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (win_idle.vld) begin
               state_nxt = HOLD;
               grant_nxt = 4'b0001 << win_idle.idx;
               ptr_nxt   = win_idle.idx;
               dwell_nxt = '0;
            end
         end
         HOLD: begin
`ifdef DISP_ARB_PREEMPT_EN
            if (ptr != 2'd0 && req[0] && !req0_q) begin
               grant_nxt = 4'b0001;
               ptr_nxt   = 2'd0;
               dwell_nxt = '0;
            end else
`endif
            if (!req[ptr]) begin
               dwell_nxt = '0;
               if (win_fall.vld) begin
                  grant_nxt = 4'b0001 << win_fall.idx;
                  ptr_nxt   = win_fall.idx;
               end else begin
                  grant_nxt = '0;
                  state_nxt = IDLE;
               end
            end else if (dwell == DW'(DWELL_TICKS)) begin
               if (win_rot.vld) begin
                  grant_nxt = 4'b0001 << win_rot.idx;
                  ptr_nxt   = win_rot.idx;
                  dwell_nxt = '0;
               end
            end else if (tick) begin
               dwell_nxt = dwell + DW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         grant <= '0;
         dwell <= '0;
         ptr   <= 2'd3;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         dwell <= dwell_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Live data of the granted source passes straight through; nothing is latched.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      seven_seg_src_gate u_gate (
         .sel    (grant[i]),
         .number (num_flat[32*i +: 32]),
         .mode   (mode_in[i]),
         .points (dp_flat[8*i +: 8]),
         .gated  (gated[i])
      );
   end

   always_comb begin
      merged = '0;
      for (int i = 0; i < NUM_SRC; i++) merged = merged | gated[i];
   end

   assign {disp_mode, disp_points, disp_number} = merged;
   assign disp_active = |grant;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed bench for seven_seg_display_arbiter with CLK_PER_TICK=4, DWELL_TICKS=3 (12-cycle dwell).
module tb_seven_seg_display_arbiter;
   localparam int CPT = 4;
   localparam int DWT = 3;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] num_flat;
   logic [3:0]   mode_in;
   logic [31:0]  dp_flat;
   logic [3:0]   grant;
   logic [31:0]  disp_number;
   logic         disp_mode;
   logic [7:0]   disp_points;
   logic         disp_active;
   logic         tick;

   int checks = 0;
   int errors = 0;

   seven_seg_display_arbiter #(.CLK_PER_TICK(CPT), .DWELL_TICKS(DWT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req         (req),
      .num_flat    (num_flat),
      .mode_in     (mode_in),
      .dp_flat     (dp_flat),
      .grant       (grant),
      .disp_number (disp_number),
      .disp_mode   (disp_mode),
      .disp_points (disp_points),
      .disp_active (disp_active),
      .tick        (tick)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] num1;
      logic [3:0]  exp_grant;
      logic [31:0] exp_num;
      logic        exp_mode;
      logic [7:0]  exp_dp;
   } vec_t;

   vec_t tv [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Leaves reset_n released 1 time unit after a rising edge; next edge is "edge 1".
   task automatic do_reset(input logic [3:0] r);
      reset_n = 1'b0;
      req     = r;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic set_data();
      num_flat = {32'h3333_3333, 32'h2222_2222, 32'h0000_1234, 32'hAAAA_0000};
      mode_in  = 4'b1010;
      dp_flat  = {8'h0F, 8'h80, 8'h04, 8'h01};
   endtask

   initial begin
      logic [3:0] exp_g;
      set_data();
      tv[0] = '{4'b0000, 32'h0000_1234, 4'b0000, 32'h0000_0000, 1'b0, 8'h00};
      tv[1] = '{4'b0010, 32'h0000_1234, 4'b0010, 32'h0000_1234, 1'b1, 8'h04};
      tv[2] = '{4'b0010, 32'h0000_5678, 4'b0010, 32'h0000_5678, 1'b1, 8'h04};
      tv[3] = '{4'b0110, 32'h0000_5678, 4'b0010, 32'h0000_5678, 1'b1, 8'h04};
      tv[4] = '{4'b0100, 32'h0000_5678, 4'b0100, 32'h2222_2222, 1'b0, 8'h80};
      tv[5] = '{4'b0000, 32'h0000_5678, 4'b0000, 32'h0000_0000, 1'b0, 8'h00};

      // Reset state
      reset_n = 1'b0;
      step();
      chk("rst_grant",  64'(grant), 64'h0);
      chk("rst_number", 64'(disp_number), 64'h0);
      chk("rst_mode",   64'(disp_mode), 64'h0);
      chk("rst_points", 64'(disp_points), 64'h0);
      chk("rst_active", 64'(disp_active), 64'h0);
      chk("rst_tick",   64'(tick), 64'h0);

      // Table-driven mux / early release vectors
      do_reset(4'b0000);
      for (int i = 0; i < 6; i++) begin
         req = tv[i].req;
         num_flat[63:32] = tv[i].num1;
         step();
         chk($sformatf("tv%0d_grant", i),  64'(grant), 64'(tv[i].exp_grant));
         chk($sformatf("tv%0d_number", i), 64'(disp_number), 64'(tv[i].exp_num));
         chk($sformatf("tv%0d_mode", i),   64'(disp_mode), 64'(tv[i].exp_mode));
         chk($sformatf("tv%0d_points", i), 64'(disp_points), 64'(tv[i].exp_dp));
         chk($sformatf("tv%0d_active", i), 64'(disp_active), 64'(tv[i].exp_grant != 4'b0000));
      end
      set_data();

      // Single source held indefinitely; data follows in the same cycle
      do_reset(4'b0010);
      for (int n = 1; n <= 30; n++) begin
         step();
         chk($sformatf("single_grant_e%0d", n), 64'(grant), 64'h2);
      end
      num_flat[63:32] = 32'h0000_5678;
      #1;
      chk("single_follow_num", 64'(disp_number), 64'h5678);
      chk("single_mode", 64'(disp_mode), 64'h1);
      chk("single_points", 64'(disp_points), 64'h04);
      set_data();

      // Rotation with all four requesting, plus tick phase
      do_reset(4'b1111);
      for (int n = 1; n <= 60; n++) begin
         step();
         exp_g = 4'b0001 << (((n - 1) / 12) % 4);
         chk($sformatf("rot_grant_e%0d", n), 64'(grant), 64'(exp_g));
         chk($sformatf("rot_tick_e%0d", n), 64'(tick), 64'((n % 4) == 3));
      end

      // Asynchronous reset mid-grant, then fresh grant after release
      reset_n = 1'b0;
      #1;
      chk("async_rst_grant",  64'(grant), 64'h0);
      chk("async_rst_number", 64'(disp_number), 64'h0);
      chk("async_rst_active", 64'(disp_active), 64'h0);
      req = 4'b0100;
      step();
      chk("in_rst_grant", 64'(grant), 64'h0);
      reset_n = 1'b1;
      step();
      chk("post_rst_grant", 64'(grant), 64'h4);

      // Early release with no dead cycle
      do_reset(4'b0110);
      step();
      chk("early_g1", 64'(grant), 64'h2);
      step();
      step();
      chk("early_g1_held", 64'(grant), 64'h2);
      req = 4'b0100;
      step();
      chk("early_switch", 64'(grant), 64'h4);
      chk("early_number", 64'(disp_number), 64'h2222_2222);
      req = 4'b0000;
      step();
      chk("early_idle_grant", 64'(grant), 64'h0);
      chk("early_idle_number", 64'(disp_number), 64'h0);

      // Saturated dwell then a new requester
      do_reset(4'b1000);
      for (int n = 1; n <= 40; n++) begin
         step();
         chk($sformatf("sat_grant_e%0d", n), 64'(grant), 64'h8);
      end
      req = 4'b1001;
      step();
      chk("sat_rotate", 64'(grant), 64'h1);

      // Source 0 arrives one tick into source 2's grant
      do_reset(4'b0100);
      for (int n = 1; n <= 5; n++) step();
      chk("pre_a_base", 64'(grant), 64'h4);
      req = 4'b0101;
      for (int n = 6; n <= 13; n++) begin
         step();
`ifdef DISP_ARB_PREEMPT_EN
         exp_g = 4'b0001;
`else
         exp_g = (n < 13) ? 4'b0100 : 4'b0001;
`endif
         chk($sformatf("pre_a_e%0d", n), 64'(grant), 64'(exp_g));
      end

      // Same with source 3 also waiting
      do_reset(4'b0100);
      for (int n = 1; n <= 5; n++) step();
      req = 4'b1101;
      for (int n = 6; n <= 18; n++) begin
         step();
`ifdef DISP_ARB_PREEMPT_EN
         exp_g = (n < 17) ? 4'b0001 : 4'b0100;
`else
         exp_g = (n < 13) ? 4'b0100 : 4'b1000;
`endif
         chk($sformatf("pre_b_e%0d", n), 64'(grant), 64'(exp_g));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seven_seg_display_arbiter.md
Name: seven_seg_display_arbiter

Overview:
- Shares the single 8-digit seven-segment display datapath (number, decimal/hex mode, decimal points) among 4 requesters, e.g. calculator result, operand entry, error banner, status.
- Round-robin grant with a minimum dwell time measured in ms ticks from an internal prescaler.
- Outputs feed the display FSM's input_number, mode and dec_points inputs directly.

Parameters:
- CLK_PER_TICK, 100000, clock cycles per dwell tick (1 ms at 100 MHz); legal range >= 2.
- DWELL_TICKS, 1000, minimum ticks a grant is held before rotating when others are waiting; legal range >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  4  request per source; level-sensitive, held while the source wants the display.
- num_flat  input  128  source i number in bits [32*i+31 : 32*i].
- mode_in  input  4  source i mode: 0 = decimal, 1 = hex.
- dp_flat  input  32  source i decimal points in bits [8*i+7 : 8*i].
- grant  output  4  one-hot registered grant, or 0 when idle.
- disp_number  output  32  selected number.
- disp_mode  output  1  selected mode.
- disp_points  output  8  selected decimal points.
- disp_active  output  1  1 when grant != 0.
- tick  output  1  one-cycle prescaler pulse, for debug and bench sync.

Behaviour:
- Reset, asynchronous assert and synchronous-safe release:
  - grant = 0, disp_number = 0, disp_mode = 0, disp_points = 0, disp_active = 0, tick = 0.
  - Prescaler = 0, dwell counter = 0, RR pointer = 3 (so source 0 wins first), state = IDLE.
  - A reset mid-grant aborts immediately; there is no completion pulse.
- Prescaler:
  - Free-running counter 0..CLK_PER_TICK-1; tick is high on the cycle the count equals CLK_PER_TICK-1.
  - Runs in all states.
- Data mux:
  - Combinational from the grant register; the granted source's live data passes through every cycle and is not latched.
  - grant = 0 drives all data outputs to 0.
- Arbitration function:
  - Winner = first set req bit searching upward, with wrap, starting at RR pointer + 1 (mod 4).
  - RR pointer is updated to the winner index whenever a new grant is issued.
- State IDLE:
  - grant = 0.
  - If any req is set at clock edge k, grant becomes the winner at edge k (visible the cycle after req is first sampled), dwell counter = 0, go to HOLD.
- State HOLD (source g granted):
  - Dwell counter increments on each tick and saturates at DWELL_TICKS.
  - req[g] falls: at the same edge, re-arbitrate over the remaining requests. Grant the winner with dwell = 0, or go to IDLE with grant = 0 if none. No dead cycle between grants.
  - Dwell counter == DWELL_TICKS and any other req set: rotate to the winner (excluding g), dwell = 0.
  - Dwell counter == DWELL_TICKS and no other req: keep g, hold the counter saturated, rotate as soon as another req appears.
  - New requests arriving before dwell expiry wait; there is no preemption unless the optional feature is compiled in.
- Simultaneous events:
  - req[g] fall and dwell expiry on the same edge: handled as the fall case.
  - All req fall together: IDLE next edge.
  - Multiple new requests: RR order decides.
- Invariants:
  - grant is always zero or one-hot.
  - grant[i] = 1 implies req[i] was 1 at the edge that issued or retained it.
  - No source waits longer than 3 × DWELL_TICKS ticks while continuously requesting.

Optional Feature:
- DISP_ARB_PREEMPT_EN defined:
  - req[0] (error banner) preempts. In HOLD with g != 0, req[0] rising causes grant = 0001 at the next edge regardless of dwell; dwell = 0; RR pointer = 0.
  - While source 0 holds, dwell expiry still rotates to other requesters normally.
- Undefined: source 0 is an ordinary round-robin participant.

Test Plan (CLK_PER_TICK = 4, DWELL_TICKS = 3, i.e. dwell 12 cycles):
- Reset: assert reset_n = 0 mid-grant -> grant = 0, disp_number = 0, disp_active = 0 immediately (asynchronous); after release, req = 0100 -> grant = 0100 one edge later.
- Single source: req = 0010, num = 0x0000_1234, mode = 1, dp = 0x04 -> disp_number = 0x1234, disp_mode = 1, disp_points = 0x04; grant held indefinitely; change num to 0x5678 -> output follows the same cycle.
- Rotation: req = 1111 from reset -> grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 12 cycles (3 ticks).
- Early release: grant = 0010 with req = 0110, drop req[1] after 2 cycles -> grant = 0100 at the next edge with no zero cycle; drop all req -> grant = 0, disp_number = 0.
- Saturated dwell: req = 1000 alone for 40 cycles, then raise req[0] -> grant = 0001 at the next edge.
- Preemption, macro on: grant = 0100 one tick in, raise req[0] -> grant = 0001 at the next edge. Macro off: same stimulus -> grant switches only at dwell expiry, to 1000 if req[3] set, else 0001.
